// File: rtl/reg_writeback_queue.sv
// Purpose : in-order writeback FIFO in front of the register-file write port, with newest-value forwarding.
// Latency : a request accepted at edge k reaches RegWrite/WriteRegister/WriteData at edge k+1 when at the head.
// Backpressure: in_ready drops once two free slots are no longer guaranteed; producers hold requests until accepted.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   a_valid/a_reg/a_data           ALU writeback request (accepted first)
//   b_valid/b_reg/b_data           load writeback request (accepted second, newer than A)
//   in_ready                       both producers may present a request this cycle
//   q1_reg/q1_hit/q1_data          forwarding query 1 (newest pending value)
//   q2_reg/q2_hit/q2_data          forwarding query 2
//   RegWrite/WriteRegister/WriteData  register-file write port
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_reg,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_reg,
  input  logic [31:0] b_data,
  output logic        in_ready,
  input  logic [4:0]  q1_reg,
  input  logic [4:0]  q2_reg,
  output logic        q1_hit,
  output logic        q2_hit,
  output logic [31:0] q1_data,
  output logic [31:0] q2_data,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData
);

  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } wb_entry_t;

  wb_entry_t       mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  logic            push_a;
  logic            push_b;
  logic            pop;
  logic [1:0]      n_push;
  logic [AW-1:0]   b_slot;

  // Only registered count is used, so a same-cycle pop never opens a slot early.
  assign in_ready = (count <= CW'(DEPTH - 2));

  // Writes to r0 never occupy a slot.
  assign push_a = in_ready && a_valid && (a_reg != 5'd0);
  assign push_b = in_ready && b_valid && (b_reg != 5'd0);
  assign n_push = {1'b0, push_a} + {1'b0, push_b};
  assign b_slot = push_a ? (wr_ptr + AW'(1)) : wr_ptr;

  // Pop decision uses count before this edge's enqueue.
  assign pop = (count != '0);

  // Entry storage needs no reset: count=0 marks every slot invalid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_a) mem[wr_ptr] <= '{rd: a_reg, dat: a_data};
      if (push_b) mem[b_slot] <= '{rd: b_reg, dat: b_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      wr_ptr   <= wr_ptr + AW'(n_push);
      count    <= count + CW'(n_push) - CW'(pop);
      RegWrite <= pop;
      if (pop) begin
        rd_ptr        <= rd_ptr + AW'(1);
        WriteRegister <= mem[rd_ptr].rd;
        WriteData     <= mem[rd_ptr].dat;
      end
    end
  end

  // Forwarding: output stage is lowest priority; FIFO entries are scanned
  // oldest to youngest so the youngest match overrides.
  logic [AW-1:0] idx;
  always_comb begin
    q1_hit  = 1'b0;
    q1_data = 32'd0;
    q2_hit  = 1'b0;
    q2_data = 32'd0;
    idx     = '0;
    if (RegWrite && (q1_reg != 5'd0) && (WriteRegister == q1_reg)) begin
      q1_hit  = 1'b1;
      q1_data = WriteData;
    end
    if (RegWrite && (q2_reg != 5'd0) && (WriteRegister == q2_reg)) begin
      q2_hit  = 1'b1;
      q2_data = WriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (CW'(i) < count) begin
        if ((q1_reg != 5'd0) && (mem[idx].rd == q1_reg)) begin
          q1_hit  = 1'b1;
          q1_data = mem[idx].dat;
        end
        if ((q2_reg != 5'd0) && (mem[idx].rd == q2_reg)) begin
          q2_hit  = 1'b1;
          q2_data = mem[idx].dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
module tb_reg_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_reg, b_reg;
  logic [31:0] a_data, b_data;
  logic        in_ready;
  logic [4:0]  q1_reg, q2_reg;
  logic        q1_hit, q2_hit;
  logic [31:0] q1_data, q2_data;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;

  reg_writeback_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data),
    .in_ready(in_ready),
    .q1_reg(q1_reg), .q2_reg(q2_reg),
    .q1_hit(q1_hit), .q2_hit(q2_hit),
    .q1_data(q1_data), .q2_data(q2_data),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  // Reference model: pending writes as a plain queue of {reg,data}, plus the
  // register-file port contents. exp_q is the scoreboard of writes still owed.
  logic [36:0] fifo_q[$];
  logic [36:0] exp_q[$];
  bit          m_out_v = 0;
  logic [4:0]  m_out_r = '0;
  logic [31:0] m_out_d = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] q);
    if (q == 5'd0) return 33'd0;
    for (int i = fifo_q.size() - 1; i >= 0; i--)
      if (fifo_q[i][36:32] == q) return {1'b1, fifo_q[i][31:0]};
    if (m_out_v && m_out_r == q) return {1'b1, m_out_d};
    return 33'd0;
  endfunction

  // Drive one cycle: called just after a negedge, returns just after the next negedge.
  task automatic step(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                      input bit bv, input logic [4:0] br, input logic [31:0] bd,
                      input logic [4:0] x1, input logic [4:0] x2, input bit r);
    logic [32:0] f1, f2;
    logic [36:0] e;
    bit rdy;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    q1_reg = x1; q2_reg = x2; rst = r;
    #1;
    rdy = (fifo_q.size() <= DEPTH - 2);
    f1 = model_fwd(x1);
    f2 = model_fwd(x2);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("RegWrite", 64'(RegWrite), 64'(m_out_v));
    chk("WriteRegister", 64'(WriteRegister), 64'(m_out_r));
    chk("WriteData", 64'(WriteData), 64'(m_out_d));
    chk("q1_fwd", 64'({q1_hit, q1_data}), 64'(f1));
    chk("q2_fwd", 64'({q2_hit, q2_data}), 64'(f2));
    @(posedge clk);
    if (r) begin
      fifo_q.delete();
      exp_q.delete();
      m_out_v = 0; m_out_r = '0; m_out_d = '0;
    end else begin
      if (fifo_q.size() > 0) begin
        e = fifo_q.pop_front();
        m_out_v = 1; m_out_r = e[36:32]; m_out_d = e[31:0];
      end else begin
        m_out_v = 0;
      end
      if (rdy && av && ar != 5'd0) begin fifo_q.push_back({ar, ad}); exp_q.push_back({ar, ad}); end
      if (rdy && bv && br != 5'd0) begin fifo_q.push_back({br, bd}); exp_q.push_back({br, bd}); end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [4:0] x1, input int n);
    for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, x1, 5'd0, 0);
  endtask

  // Scoreboard monitor: every register-file write must be the next owed write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (started && RegWrite === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra: unexpected write reg=%0d data=%h", WriteRegister, WriteData);
      end else begin
        e = exp_q.pop_front();
        if ({WriteRegister, WriteData} !== e) begin
          failures++;
          $display("FAIL sb_order: got reg=%0d data=%h expected reg=%0d data=%h",
                   WriteRegister, WriteData, e[36:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    int k;
    rst = 1; a_valid = 0; b_valid = 0; a_reg = '0; b_reg = '0;
    a_data = '0; b_data = '0; q1_reg = '0; q2_reg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    started = 1;
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd0, 5'd0, 1);

    // Single A write with forwarding visible until it leaves the output stage.
    step(1, 5'd5, 32'h11, 0, 5'd0, 32'd0, 5'd5, 5'd0, 0);
    idle(5'd5, 3);

    // Same destination from A and B: B wins.
    step(1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB, 5'd3, 5'd0, 0);
    idle(5'd3, 4);

    // Dual requests every cycle, held until accepted.
    k = 0;
    while (k < 4) begin
      bit acc;
      acc = (fifo_q.size() <= DEPTH - 2);
      step(1, 5'(2*k+1), 32'h100 + 32'(k), 1, 5'(2*k+2), 32'h200 + 32'(k),
           5'(2*k+1), 5'(2*k+2), 0);
      if (acc) k++;
    end
    idle(5'd8, 6);

    // Write to r0 is dropped; r0 query never hits.
    step(1, 5'd0, 32'hDEAD, 1, 5'd7, 32'h77, 5'd0, 5'd7, 0);
    idle(5'd0, 3);

    // Fill three entries, then reset mid-drain.
    step(1, 5'd9, 32'h9, 1, 5'd10, 32'hA, 5'd9, 5'd10, 0);
    step(1, 5'd11, 32'hB, 1, 5'd12, 32'hC, 5'd11, 5'd12, 0);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd11, 5'd12, 1);
    idle(5'd12, 4);

    // Single A request every cycle: sustained one write per cycle.
    for (int i = 0; i < 10; i++)
      step(1, 5'(13 + i), 32'hC000 + 32'(i), 0, 5'd0, 32'd0, 5'(12 + i), 5'(13 + i), 0);
    idle(5'd20, 3);

    // Randomized traffic with small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           ($urandom_range(0, 59) == 0));
    end
    idle(5'd1, 8);

    chk("drained", 64'(exp_q.size()), 64'd0);
    started = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
